// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for the sequential compare unit.
//   sz_e     : operand-size encodings as seen on sz_i
//   state_e  : FSM states of cmp_unit_seq
//   width_of : maps a size code to the effective operand width, clamped to
//              the datapath width
package cmp_pkg;

  typedef enum logic [1:0] {
    SZ_8   = 2'b00,
    SZ_16  = 2'b01,
    SZ_32  = 2'b10,
    SZ_DBW = 2'b11
  } sz_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Size code 11, or any size wider than the datapath, falls back to dbw.
  function automatic int unsigned width_of(input logic [1:0] sz,
                                           input int unsigned dbw);
    int unsigned w;
    case (sz)
      SZ_8:    w = 8;
      SZ_16:   w = 16;
      SZ_32:   w = 32;
      default: w = dbw;
    endcase
    if (w > dbw) begin
      w = dbw;
    end
    return w;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// cmp_slice: one SLICE-bit step of a - b, done as a + ~b + cin.
//   a, b   : slice operands
//   cin    : carry in (NOT borrow in); 1 for the lowest slice
//   d      : slice difference
//   cout   : carry out of the slice msb (NOT borrow out)
//   c_msb  : carry into the slice msb; XOR with cout gives signed overflow
module cmp_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] d,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0]   sum;
  logic [SLICE-1:0] b_n;

  always_comb begin
    b_n   = ~b;
    sum   = {1'b0, a} + {1'b0, b_n} + {{SLICE{1'b0}}, cin};
    d     = sum[SLICE-1:0];
    cout  = sum[SLICE];
    // The msb sum bit is a ^ ~b ^ carry_in, so the carry into the msb can be
    // recovered from the sum; this also holds for SLICE=1 (gives cin).
    c_msb = a[SLICE-1] ^ b_n[SLICE-1] ^ d[SLICE-1];
  end

endmodule

// File: rtl/cmp_unit_seq.sv
// cmp_unit_seq: multi-cycle compare (a - b) with 6502-style flags.
// Processes one SLICE-bit slice per clock with the carry chained between
// slices, at an operand width of 8, 16 or 32 bits (clamped to DBW).
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : request a compare, accepted only while ready_o=1
//   sz_i       : operand size 00=8, 01=16, 10=32, 11=DBW
//   signed_i   : ge_s_o gives signed (1) or unsigned (0) a>=b
//   a_i, b_i   : minuend / subtrahend, latched on acceptance
//   ready_o    : idle, a start will be accepted
//   done_o     : one-cycle pulse, results valid from this cycle on
//   o_o        : a-b at width W, upper bits zero
//   c_o,z_o,n_o,v_o : carry (NOT borrow), zero, negative, signed overflow
//   ge_s_o     : a>=b, signed or unsigned as selected by signed_i
module cmp_unit_seq
  import cmp_pkg::*;
#(
  parameter int unsigned DBW   = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [1:0]     sz_i,
  input  logic           signed_i,
  input  logic [DBW-1:0] a_i,
  input  logic [DBW-1:0] b_i,
  output logic           ready_o,
  output logic           done_o,
  output logic [DBW-1:0] o_o,
  output logic           c_o,
  output logic           z_o,
  output logic           n_o,
  output logic           v_o,
  output logic           ge_s_o
);

  localparam int unsigned NSL  = DBW / SLICE;
  localparam int unsigned IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  state_e          state_q, state_d;
  logic [DBW-1:0]  a_q, a_d;
  logic [DBW-1:0]  b_q, b_d;
  logic [DBW-1:0]  res_q, res_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] last_q, last_d;
  logic            sgn_q, sgn_d;
  logic            cin_q, cin_d;
  logic            zacc_q, zacc_d;

  logic            done_q, done_d;
  logic [DBW-1:0]  o_q, o_d;
  logic            c_q, c_d;
  logic            z_q, z_d;
  logic            n_q, n_d;
  logic            v_q, v_d;
  logic            ge_q, ge_d;

  int unsigned     w_acc;
  logic [DBW-1:0]  op_mask;
  int unsigned     lo;
  logic [SLICE-1:0] a_sl, b_sl, d_sl;
  logic            cout, c_msb;

  // Slice select: shifting the operand down avoids a variable part-select.
  always_comb begin
    lo   = 32'(idx_q) * SLICE;
    a_sl = SLICE'(a_q >> lo);
    b_sl = SLICE'(b_q >> lo);
  end

  cmp_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (cin_q),
    .d     (d_sl),
    .cout  (cout),
    .c_msb (c_msb)
  );

  // Effective width and operand mask for a request presented this cycle.
  always_comb begin
    w_acc   = width_of(sz_i, DBW);
    op_mask = '1;
    op_mask = op_mask >> (DBW - w_acc);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sgn_d   = sgn_q;
    cin_d   = cin_q;
    zacc_d  = zacc_q;
    done_d  = 1'b0;
    o_d     = o_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    ge_d    = ge_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i & op_mask;
          b_d     = b_i & op_mask;
          sgn_d   = signed_i;
          last_d  = IDXW'(w_acc / SLICE - 1);
          idx_d   = '0;
          cin_d   = 1'b1;
          zacc_d  = 1'b1;
          // Cleared shadow keeps every slice above W at zero, so the final
          // result needs no separate width mask.
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = res_q | (DBW'(d_sl) << lo);
        zacc_d = zacc_q & (d_sl == '0);
        cin_d  = cout;
        idx_d  = idx_q + 1'b1;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          o_d     = res_d;
          c_d     = cout;
          z_d     = zacc_d;
          n_d     = d_sl[SLICE-1];
          v_d     = c_msb ^ cout;
          ge_d    = sgn_q ? ~(d_sl[SLICE-1] ^ (c_msb ^ cout)) : cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      sgn_q   <= 1'b0;
      cin_q   <= 1'b0;
      zacc_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      ge_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      sgn_q   <= sgn_d;
      cin_q   <= cin_d;
      zacc_q  <= zacc_d;
      done_q  <= done_d;
      o_q     <= o_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      ge_q    <= ge_d;
    end
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    done_o  = done_q;
    o_o     = o_q;
    c_o     = c_q;
    z_o     = z_q;
    n_o     = n_q;
    v_o     = v_q;
    ge_s_o  = ge_q;
  end

endmodule
